mdc_frame_ctrl: RTL and testbench

Frame sequencer for the radix-4 MDC 32-point FFT pipeline. It accepts 4-sample input beats through a valid/ready handshake and issues the single-cycle `start_mdc_o` pulse to the datapath. It enforces contiguous 8-beat frames and the minimum start spacing the datapath's internal stage counter needs. It also generates the output-side framing (`out_valid_o`, `out_sof_o`, `out_eof_o`, `out_err_o`) aligned to the datapath's fixed result latency.

---
 rtl/mdc_ctrl_pkg.sv | 22 ++
 rtl/mdc_frame_ctrl_sat_counter.sv | 30 +++
 rtl/mdc_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mdc_frame_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mdc_ctrl_pkg.sv
// Shared types and defaults for the MDC FFT frame controller.
package mdc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } mdc_state_e;

  localparam int unsigned MDC_BEATS       = 8;
  localparam int unsigned MDC_OUT_LAT     = 28;
  localparam int unsigned MDC_MIN_SPACING = 40;
  localparam int unsigned MDC_CNT_W       = 6;

  // True when v lies in the inclusive range [lo, hi].
  function automatic logic cnt_in_range(input int unsigned v,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/mdc_frame_ctrl_sat_counter.sv
// Clear/enable up-counter that holds at LIMIT; reset and clear values are parameters.
module mdc_sat_counter #(
  parameter int unsigned W       = 6,
  parameter int unsigned LIMIT   = 63,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned CLR_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt;

  // Reset has priority, then clear, then a saturating increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= W'(RST_VAL);
    end else if (clr_i) begin
      cnt <= W'(CLR_VAL);
    end else if (en_i && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign cnt_o = cnt;

endmodule

// File: rtl/mdc_frame_ctrl.sv
// Frame sequencer for the radix-4 MDC 32-point FFT: input handshake, start
// pulse, minimum start spacing and output-side framing.
module mdc_frame_ctrl
  import mdc_ctrl_pkg::*;
#(
  parameter int unsigned BEATS       = MDC_BEATS,
  parameter int unsigned OUT_LAT     = MDC_OUT_LAT,
  parameter int unsigned MIN_SPACING = MDC_MIN_SPACING,
  parameter int unsigned CNT_W       = MDC_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        in_valid_i,
  input  logic        in_sof_i,
  output logic        in_ready_o,
  output logic        start_mdc_o,
  output logic        out_valid_o,
  output logic        out_sof_o,
  output logic        out_eof_o,
  output logic        out_err_o,
  output logic        busy_o,
  output logic        err_gap_o,
  output logic        err_sof_o,
  output logic        err_drop_o,
  input  logic        err_clr_i,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned BW      = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;
  // Outputs are registered decodes, so the window is decoded one count early.
  localparam int unsigned WIN_LO  = OUT_LAT - 1;
  localparam int unsigned WIN_HI  = OUT_LAT + BEATS - 2;

  if (OUT_LAT + BEATS > MIN_SPACING) begin : g_chk_overlap
    $error("mdc_frame_ctrl: OUT_LAT + BEATS must not exceed MIN_SPACING");
  end
  if (CNT_MAX < MIN_SPACING) begin : g_chk_cnt_w
    $error("mdc_frame_ctrl: CNT_W too small for MIN_SPACING");
  end
  if (OUT_LAT < 1) begin : g_chk_lat
    $error("mdc_frame_ctrl: OUT_LAT must be at least 1");
  end

  mdc_state_e    state;
  logic          start;
  logic          in_load;
  logic          in_idle;
  logic [CNT_W-1:0] cyc;
  logic [BW-1:0] beat;
  logic          bad;
  logic          gap_ev;
  logic          sof_ev;
  logic          drop_ev;
  logic          in_win;
  logic          ov_q;
  logic          sof_q;
  logic          eof_q;
  logic          err_q;
  logic          gap_q;
  logic          sofe_q;
  logic          drop_q;
  logic [15:0]   fcnt;

  assign in_idle = (state == IDLE);
  assign in_load = (state == LOAD);

  assign start       = ~rst_i & in_idle & enable_i & in_valid_i & in_sof_i;
  assign start_mdc_o = start;
  assign in_ready_o  = ~rst_i & (in_idle ? enable_i : in_load);

  assign gap_ev  = in_load & ~in_valid_i;
  assign sof_ev  = in_load & in_valid_i & in_sof_i;
  assign drop_ev = in_idle & enable_i & in_valid_i & ~in_sof_i;

  // Both counters load 1 on the start edge so each holds the index of the
  // current cycle relative to the start cycle (which is index 0).
  mdc_sat_counter #(
    .W       (CNT_W),
    .LIMIT   (CNT_MAX),
    .RST_VAL (CNT_MAX),
    .CLR_VAL (1)
  ) u_cyc_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start),
    .en_i  (1'b1),
    .cnt_o (cyc)
  );

  mdc_sat_counter #(
    .W       (BW),
    .LIMIT   (BEATS - 1),
    .RST_VAL (0),
    .CLR_VAL (1)
  ) u_beat_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start),
    .en_i  (in_load),
    .cnt_o (beat)
  );

  // Frame state: accept in IDLE, consume fixed beat slots in LOAD, hold off in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: if (beat == BW'(BEATS - 1)) state <= WAIT;
        WAIT: if (cyc >= CNT_W'(MIN_SPACING - 1)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-frame bad flag, cleared by each start and set by any input gap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bad <= 1'b0;
    end else if (start) begin
      bad <= 1'b0;
    end else if (gap_ev) begin
      bad <= 1'b1;
    end
  end

  assign in_win = cnt_in_range(int'(cyc), WIN_LO, WIN_HI);

  // Registered output framing decoded from the cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ov_q  <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ov_q  <= in_win;
      sof_q <= (cyc == CNT_W'(WIN_LO));
      eof_q <= (cyc == CNT_W'(WIN_HI));
      err_q <= in_win & bad;
    end
  end

  // Completed output frames, counted on the last output beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt <= '0;
    end else if (eof_q) begin
      fcnt <= fcnt + 16'd1;
    end
  end

  // Sticky error flags; a coincident event wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q  <= 1'b0;
      sofe_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      gap_q  <= (gap_q  & ~err_clr_i) | gap_ev;
      sofe_q <= (sofe_q & ~err_clr_i) | sof_ev;
      drop_q <= (drop_q & ~err_clr_i) | drop_ev;
    end
  end

  assign out_valid_o = ov_q;
  assign out_sof_o   = sof_q;
  assign out_eof_o   = eof_q;
  assign out_err_o   = err_q;
  assign busy_o      = ~rst_i & (~in_idle | ov_q);
  assign err_gap_o   = gap_q;
  assign err_sof_o   = sofe_q;
  assign err_drop_o  = drop_q;
  assign frame_cnt_o = fcnt;

endmodule

// File: tb/tb_mdc_frame_ctrl.sv
// Self-checking bench for mdc_frame_ctrl against a start-time based reference model.
module tb_mdc_frame_ctrl;

  localparam int BEATS   = 8;
  localparam int OUT_LAT = 28;
  localparam int MIN_SP  = 40;

  logic        clk = 1'b0;
  logic        rst_i, enable_i, in_valid_i, in_sof_i, err_clr_i;
  logic        in_ready_o, start_mdc_o, out_valid_o, out_sof_o, out_eof_o, out_err_o;
  logic        busy_o, err_gap_o, err_sof_o, err_drop_o;
  logic [15:0] frame_cnt_o;

  always #5 clk = ~clk;

  mdc_frame_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .in_valid_i  (in_valid_i),
    .in_sof_i    (in_sof_i),
    .in_ready_o  (in_ready_o),
    .start_mdc_o (start_mdc_o),
    .out_valid_o (out_valid_o),
    .out_sof_o   (out_sof_o),
    .out_eof_o   (out_eof_o),
    .out_err_o   (out_err_o),
    .busy_o      (busy_o),
    .err_gap_o   (err_gap_o),
    .err_sof_o   (err_sof_o),
    .err_drop_o  (err_drop_o),
    .err_clr_i   (err_clr_i),
    .frame_cnt_o (frame_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: everything derives from the absolute time of the last start.
  int t      = 0;
  bit ls_ok  = 0;
  int ls     = 0;
  bit m_bad  = 0;
  int m_fcnt = 0;
  bit m_gap  = 0;
  bit m_sofe = 0;
  bit m_drop = 0;

  task automatic cycle(input bit chk);
    int rel;
    bit idle, load, win, exp_start, exp_ready;
    @(negedge clk);
    rel       = t - ls;
    idle      = !ls_ok || (rel >= MIN_SP);
    load      = ls_ok && (rel >= 1) && (rel <= BEATS - 1);
    win       = ls_ok && (rel >= OUT_LAT) && (rel < OUT_LAT + BEATS);
    exp_ready = !rst_i && (idle ? enable_i : load);
    exp_start = !rst_i && idle && enable_i && in_valid_i && in_sof_i;
    if (chk) begin
      check("in_ready",  32'(in_ready_o),  32'(exp_ready));
      check("start",     32'(start_mdc_o), 32'(exp_start));
      check("out_valid", 32'(out_valid_o), 32'(win));
      check("out_sof",   32'(out_sof_o),   32'(win && rel == OUT_LAT));
      check("out_eof",   32'(out_eof_o),   32'(win && rel == OUT_LAT + BEATS - 1));
      check("out_err",   32'(out_err_o),   32'(win && m_bad));
      check("busy",      32'(busy_o),      32'(!rst_i && (!idle || win)));
      check("err_gap",   32'(err_gap_o),   32'(m_gap));
      check("err_sof",   32'(err_sof_o),   32'(m_sofe));
      check("err_drop",  32'(err_drop_o),  32'(m_drop));
      check("frame_cnt", 32'(frame_cnt_o), 32'(m_fcnt));
    end
    @(posedge clk);
    if (rst_i) begin
      ls_ok = 0; m_bad = 0; m_fcnt = 0; m_gap = 0; m_sofe = 0; m_drop = 0;
    end else begin
      m_gap  = (m_gap  && !err_clr_i) || (load && !in_valid_i);
      m_sofe = (m_sofe && !err_clr_i) || (load && in_valid_i && in_sof_i);
      m_drop = (m_drop && !err_clr_i) || (idle && enable_i && in_valid_i && !in_sof_i);
      if (win && rel == OUT_LAT + BEATS - 1) m_fcnt = (m_fcnt + 1) % 65536;
      if (load && !in_valid_i) m_bad = 1;
      if (exp_start) begin
        ls_ok = 1; ls = t; m_bad = 0;
      end
    end
    t++;
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input bit e = 1, input bit c = 0);
    in_valid_i = v; in_sof_i = s; enable_i = e; err_clr_i = c; rst_i = 0;
    cycle(1);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(0, 0);
  endtask

  // First reset cycle may still show pre-reset registered outputs, so it is not checked.
  task automatic do_reset();
    rst_i = 1; in_valid_i = 0; in_sof_i = 0; enable_i = 1; err_clr_i = 0;
    cycle(0);
    cycle(1);
    rst_i = 0;
  endtask

  task automatic frame(input int gap_beat = -1, input int sof_beat = -1, input int en_drop = -1);
    for (int b = 0; b < BEATS; b++)
      drive(b != gap_beat, (b == 0) || (b == sof_beat), !(en_drop >= 0 && b >= en_drop));
  endtask

  initial begin
    rst_i = 1; enable_i = 0; in_valid_i = 0; in_sof_i = 0; err_clr_i = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single clean frame.
    frame();
    idle_n(40);

    // Back-to-back: source always valid with SOF every 8 beats.
    for (int i = 0; i < 130; i++) drive(1, (i % 8) == 0);
    idle_n(40);

    // Gap at beat 4, then a clean frame, then clear the sticky bit.
    frame(4);
    idle_n(40);
    frame();
    idle_n(40);
    drive(0, 0, 1, 1);
    idle_n(2);

    // Non-SOF beat in IDLE, then SOF mid-frame at beat 3.
    drive(1, 0);
    idle_n(2);
    frame(-1, 3);
    idle_n(40);
    drive(0, 0, 1, 1);

    // Reset at cycle 20 of a frame, then SOF on the first post-reset cycle.
    frame();
    idle_n(12);
    do_reset();
    frame();
    idle_n(40);

    // Enable low with SOF offered, then enable dropped during LOAD.
    for (int i = 0; i < 5; i++) drive(1, 1, 0);
    frame(-1, -1, 2);
    idle_n(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
